// File: rtl/aes_ctr_pkg.sv
// aes_ctr_pkg: shared widths, default AES latency and FSM state type for the CTR generator
package aes_ctr_pkg;
    localparam int NONCE_W         = 96;
    localparam int CTR_W           = 32;
    localparam int AES_LAT_DEFAULT = 24;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } fsm_t;
endpackage

// File: rtl/aes_lat_pipe.sv
// aes_lat_pipe: delays block valid and index by DEPTH cycles to line up with the AES core output
module aes_lat_pipe #(
    parameter int DEPTH = 24,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    input  logic [W-1:0] blk_idx,
    output logic         out_valid,
    output logic [W-1:0] out_idx
);
    logic         v  [DEPTH];
    logic [W-1:0] ix [DEPTH];

    // shift valid and index one stage per cycle; reset empties the whole line
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                v[i]  <= 1'b0;
                ix[i] <= '0;
            end
        end else begin
            v[0]  <= blk_valid;
            ix[0] <= blk_idx;
            for (int i = 1; i < DEPTH; i++) begin
                v[i]  <= v[i-1];
                ix[i] <= ix[i-1];
            end
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_idx   = ix[DEPTH-1];
endmodule

// File: rtl/aes_ctr_gen.sv
// aes_ctr_gen: AES-CTR counter block issuer; define CTR_WRAP_ERR_EN to stop on 32-bit counter wrap with wrap_err
module aes_ctr_gen
    import aes_ctr_pkg::*;
#(
    parameter int AES_LAT = AES_LAT_DEFAULT,
    parameter int IDX_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NONCE_W-1:0] nonce,
    input  logic [CTR_W-1:0]   ctr_init,
    input  logic [IDX_W-1:0]   num_blocks,
    input  logic               pause,
    output logic [127:0]       state,
    output logic               blk_valid,
    output logic               out_valid,
    output logic [IDX_W-1:0]   out_idx,
    output logic               busy,
    output logic               done
`ifdef CTR_WRAP_ERR_EN
    ,
    output logic               wrap_err
`endif
);
    fsm_t               st, st_n;
    logic [NONCE_W-1:0] nonce_q;
    logic [CTR_W-1:0]   ctr_q;
    logic [IDX_W-1:0]   num_q;
    logic [IDX_W-1:0]   idx_q;
    logic               issue, last, wrap;

    assign issue     = (st == S_RUN) && !pause;
    assign last      = idx_q == num_q - 1'b1;
`ifdef CTR_WRAP_ERR_EN
    assign wrap      = (ctr_q == '1) && !last;
`else
    assign wrap      = 1'b0;
`endif
    assign blk_valid = issue;
    assign state     = issue ? {nonce_q, ctr_q} : '0;
    assign busy      = st != S_IDLE;
    assign done      = st == S_FIN;

    // next-state: last issue (or a pending wrap) drains, drain ends on the final block's keystream
    always_comb begin
        st_n = st;
        case (st)
            S_IDLE:  if (start) st_n = (num_blocks == '0) ? S_FIN : S_RUN;
            S_RUN:   if (issue && (last || wrap)) st_n = S_DRAIN;
            S_DRAIN: if (out_valid && out_idx == idx_q - 1'b1) st_n = S_FIN;
            S_FIN:   st_n = S_IDLE;
        endcase
    end

    // state register plus run parameters captured at start and advanced per issued block
    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= S_IDLE;
            nonce_q <= '0;
            ctr_q   <= '0;
            num_q   <= '0;
            idx_q   <= '0;
        end else begin
            st <= st_n;
            if (st == S_IDLE && start) begin
                nonce_q <= nonce;
                ctr_q   <= ctr_init;
                num_q   <= num_blocks;
                idx_q   <= '0;
            end else if (issue) begin
                ctr_q <= ctr_q + 1'b1;
                idx_q <= idx_q + 1'b1;
            end
        end
    end

`ifdef CTR_WRAP_ERR_EN
    // sticky wrap flag, cleared by reset or a newly accepted run
    always_ff @(posedge clk) begin
        if (rst || (st == S_IDLE && start)) wrap_err <= 1'b0;
        else if (issue && wrap) wrap_err <= 1'b1;
    end
`endif

    aes_lat_pipe #(.DEPTH(AES_LAT), .W(IDX_W)) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .blk_valid (issue),
        .blk_idx   (issue ? idx_q : '0),
        .out_valid (out_valid),
        .out_idx   (out_idx)
    );
endmodule

// File: tb/tb_aes_ctr_gen.sv
// tb_aes_ctr_gen: directed self-checking bench for aes_ctr_gen (AES_LAT=24, IDX_W=16)
module tb_aes_ctr_gen;
    localparam int IW = 16;
    localparam int N  = 40;
    localparam logic [95:0] NW = 96'h0123_4567_89AB_CDEF_0011_2233;

    logic          clk = 1'b0;
    logic          rst, start, pause;
    logic [95:0]   nonce;
    logic [31:0]   ctr_init;
    logic [IW-1:0] num_blocks;
    logic [127:0]  state;
    logic          blk_valid, out_valid, busy, done;
    logic [IW-1:0] out_idx;
`ifdef CTR_WRAP_ERR_EN
    logic          wrap_err;
`endif

    int pass_n = 0;
    int total_n = 0;

    logic          pz [N];
    logic          rz [N];
    logic          sz [N];
    logic          bv_l [N];
    logic [127:0]  st_l [N];
    logic          ov_l [N];
    logic [IW-1:0] oi_l [N];
    logic          dn_l [N];
    logic          by_l [N];
    logic          we_l [N];

    always #5 clk = ~clk;

    aes_ctr_gen #(.AES_LAT(24), .IDX_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nonce      (nonce),
        .ctr_init   (ctr_init),
        .num_blocks (num_blocks),
        .pause      (pause),
        .state      (state),
        .blk_valid  (blk_valid),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done)
`ifdef CTR_WRAP_ERR_EN
        ,
        .wrap_err   (wrap_err)
`endif
    );

    task automatic clear_stim();
        for (int k = 0; k < N; k++) begin
            pz[k] = 1'b0;
            rz[k] = 1'b0;
            sz[k] = 1'b0;
        end
    endtask

    task automatic sample(input int k);
        bv_l[k] = blk_valid;
        st_l[k] = state;
        ov_l[k] = out_valid;
        oi_l[k] = out_idx;
        dn_l[k] = done;
        by_l[k] = busy;
`ifdef CTR_WRAP_ERR_EN
        we_l[k] = wrap_err;
`else
        we_l[k] = 1'b0;
`endif
    endtask

    // cycle 0 presents start; cycles 1..n apply per-cycle pause/rst/start tables
    task automatic run(input logic [95:0] nn, input logic [31:0] ci, input logic [IW-1:0] nb, input int n);
        @(posedge clk); #1;
        start = 1'b1; nonce = nn; ctr_init = ci; num_blocks = nb; pause = 1'b0; rst = 1'b0;
        #1 sample(0);
        for (int k = 1; k <= n; k++) begin
            @(posedge clk); #1;
            start = sz[k]; rst = rz[k]; pause = pz[k];
            if (sz[k]) begin
                nonce = ~nn; ctr_init = 32'h100; num_blocks = 7;
            end else begin
                nonce = nn; ctr_init = ci; num_blocks = nb;
            end
            #1 sample(k);
        end
        start = 1'b0; rst = 1'b0; pause = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; pause = 1'b0; nonce = '0; ctr_init = '0; num_blocks = '0;
        repeat (3) @(posedge clk);
        #2;
        total_n++;
        if ({state, blk_valid, out_valid, out_idx, busy, done} !== '0)
            $display("FAIL reset_outputs state=%h bv=%b ov=%b idx=%0d busy=%b done=%b want all 0", state, blk_valid, out_valid, out_idx, busy, done);
        else pass_n++;
`ifdef CTR_WRAP_ERR_EN
        total_n++;
        if (wrap_err !== 1'b0) $display("FAIL reset_wrap_err got=%b want=0", wrap_err);
        else pass_n++;
`endif
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [127:0] es;
        clear_stim();
        run(96'h0, 32'h1, 3, 30);
        for (int k = 1; k <= 4; k++) begin
            es = (k <= 3) ? {96'h0, 32'(k)} : 128'h0;
            total_n++;
            if (bv_l[k] !== (k <= 3) || st_l[k] !== es)
                $display("FAIL basic_issue c%0d bv=%b state=%h want bv=%b state=%h", k, bv_l[k], st_l[k], k <= 3, es);
            else pass_n++;
        end
        for (int k = 24; k <= 28; k++) begin
            total_n++;
            if (ov_l[k] !== (k >= 25 && k <= 27) || (ov_l[k] && oi_l[k] !== IW'(k - 25)))
                $display("FAIL basic_out c%0d ov=%b idx=%0d want ov=%b idx=%0d", k, ov_l[k], oi_l[k], k >= 25 && k <= 27, k - 25);
            else pass_n++;
        end
        for (int k = 26; k <= 29; k++) begin
            total_n++;
            if (dn_l[k] !== (k == 28))
                $display("FAIL basic_done c%0d got=%b want=%b", k, dn_l[k], k == 28);
            else pass_n++;
        end
        total_n++;
        if (by_l[29] !== 1'b0) $display("FAIL basic_idle busy=%b want=0", by_l[29]);
        else pass_n++;
    endtask

    task automatic test_pause();
        logic [31:0] ec [5] = '{32'h1, 32'h0, 32'h2, 32'h3, 32'h0};
        logic        eb [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        eo [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [IW-1:0] ei [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd0};
        clear_stim();
        pz[2] = 1'b1;
        run(96'h0, 32'h1, 3, 31);
        for (int k = 1; k <= 5; k++) begin
            total_n++;
            if (bv_l[k] !== eb[k-1] || st_l[k] !== {96'h0, ec[k-1]})
                $display("FAIL pause_issue c%0d bv=%b state=%h want bv=%b ctr=%h", k, bv_l[k], st_l[k], eb[k-1], ec[k-1]);
            else pass_n++;
        end
        for (int k = 24; k <= 29; k++) begin
            total_n++;
            if (ov_l[k] !== eo[k-24] || (eo[k-24] && oi_l[k] !== ei[k-24]))
                $display("FAIL pause_out c%0d ov=%b idx=%0d want ov=%b idx=%0d", k, ov_l[k], oi_l[k], eo[k-24], ei[k-24]);
            else pass_n++;
        end
        for (int k = 28; k <= 30; k++) begin
            total_n++;
            if (dn_l[k] !== (k == 29))
                $display("FAIL pause_done c%0d got=%b want=%b", k, dn_l[k], k == 29);
            else pass_n++;
        end
    endtask

    task automatic test_zero_blocks();
        clear_stim();
        run(NW, 32'h5, 0, 3);
        for (int k = 0; k <= 3; k++) begin
            total_n++;
            if (bv_l[k] !== 1'b0 || dn_l[k] !== (k == 1) || by_l[k] !== (k == 1))
                $display("FAIL zero_blocks c%0d bv=%b done=%b busy=%b want bv=0 done=%b busy=%b", k, bv_l[k], dn_l[k], by_l[k], k == 1, k == 1);
            else pass_n++;
        end
    endtask

    task automatic test_wrap();
`ifdef CTR_WRAP_ERR_EN
        logic [31:0] ec [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0};
        logic        eb [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        int          dc = 27;
`else
        logic [31:0] ec [5] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1, 32'h0};
        logic        eb [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        int          dc = 29;
`endif
        logic [127:0] es;
        clear_stim();
        run(NW, 32'hFFFFFFFE, 4, 31);
        for (int k = 1; k <= 5; k++) begin
            es = eb[k-1] ? {NW, ec[k-1]} : 128'h0;
            total_n++;
            if (bv_l[k] !== eb[k-1] || st_l[k] !== es)
                $display("FAIL wrap_issue c%0d bv=%b state=%h want bv=%b state=%h", k, bv_l[k], st_l[k], eb[k-1], es);
            else pass_n++;
        end
        total_n++;
        if (dn_l[dc] !== 1'b1 || dn_l[dc-1] !== 1'b0)
            $display("FAIL wrap_done c%0d got=%b prev=%b want 1 after 0", dc, dn_l[dc], dn_l[dc-1]);
        else pass_n++;
        total_n++;
        if (ov_l[dc-1] !== 1'b1 || oi_l[dc-1] !== IW'(dc - 26))
            $display("FAIL wrap_last_out ov=%b idx=%0d want ov=1 idx=%0d", ov_l[dc-1], oi_l[dc-1], dc - 26);
        else pass_n++;
`ifdef CTR_WRAP_ERR_EN
        total_n++;
        if (we_l[2] !== 1'b0 || we_l[3] !== 1'b1 || we_l[31] !== 1'b1)
            $display("FAIL wrap_err got=%b%b%b want 011", we_l[2], we_l[3], we_l[31]);
        else pass_n++;
`endif
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        clear_stim();
        rz[5] = 1'b1;
        run(NW, 32'h0, 10, 36);
        total_n++;
        if (bv_l[5] !== 1'b1 || st_l[5] !== {NW, 32'h4})
            $display("FAIL rstmid_pre bv=%b state=%h want bv=1 state=%h", bv_l[5], st_l[5], {NW, 32'h4});
        else pass_n++;
        total_n++;
        if ({st_l[6], bv_l[6], ov_l[6], oi_l[6], by_l[6], dn_l[6], we_l[6]} !== '0)
            $display("FAIL rstmid_zero state=%h bv=%b ov=%b idx=%0d busy=%b done=%b want all 0", st_l[6], bv_l[6], ov_l[6], oi_l[6], by_l[6], dn_l[6]);
        else pass_n++;
        for (int k = 6; k <= 36; k++) if (ov_l[k] !== 1'b0 || by_l[k] !== 1'b0) bad++;
        total_n++;
        if (bad != 0) $display("FAIL rstmid_quiet got=%0d active cycles want=0", bad);
        else pass_n++;
    endtask

    task automatic test_busy_start();
        clear_stim();
        sz[2] = 1'b1;
        sz[28] = 1'b1;
        run(NW, 32'h1, 3, 30);
        for (int k = 1; k <= 4; k++) begin
            total_n++;
            if (bv_l[k] !== (k <= 3) || st_l[k] !== ((k <= 3) ? {NW, 32'(k)} : 128'h0))
                $display("FAIL busy_start_issue c%0d bv=%b state=%h want ctr=%0d", k, bv_l[k], st_l[k], k);
            else pass_n++;
        end
        total_n++;
        if (dn_l[28] !== 1'b1 || by_l[29] !== 1'b0 || by_l[30] !== 1'b0 || bv_l[30] !== 1'b0)
            $display("FAIL busy_start_end done=%b busy29=%b busy30=%b bv30=%b want 1 0 0 0", dn_l[28], by_l[29], by_l[30], bv_l[30]);
        else pass_n++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_pause();
        test_zero_blocks();
        test_wrap();
        test_reset_mid();
        test_busy_start();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
